// File: rtl/i2c_txff.sv
// i2c_txff: first-word-fall-through transmit byte FIFO feeding the I2C master,
// with saturated 4-bit count and sticky overflow/underflow status.
module i2c_txff #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  input  logic          i_txff_rd,
  output logic [DW-1:0] data_in,
  output logic [3:0]    data_cnt,
  output logic          ovf,
  output logic          udf,
  input  logic          clr_err
);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          pop, push;
  logic [AW:0]   nxt_level;
  assign pop       = i_txff_rd & ~empty;
  // a simultaneous pop frees a slot, so a push at full is still accepted
  assign push      = wr_en & (~full | pop);
  assign nxt_level = level + (AW+1)'(push) - (AW+1)'(pop);
  assign data_in   = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      data_cnt <= '0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr + AW'(push);
      rd_ptr   <= rd_ptr + AW'(pop);
      level    <= nxt_level;
      full     <= nxt_level == (AW+1)'(DEPTH);
      empty    <= nxt_level == '0;
      data_cnt <= (32'(nxt_level) > 32'd15) ? 4'd15 : 4'(nxt_level);
      ovf      <= (wr_en & ~push) | (ovf & ~clr_err);
      udf      <= (i_txff_rd & empty) | (udf & ~clr_err);
    end
endmodule

// File: tb/tb_i2c_txff.sv
// tb_i2c_txff: directed bench with a byte scoreboard and a small occupancy/flag model.
module tb_i2c_txff;
  logic       clk = 0, rst = 0, wr_en = 0, i_txff_rd = 0, clr_err = 0;
  logic [7:0] wr_data = 0, data_in;
  logic       full, empty, ovf, udf;
  logic [4:0] level;
  logic [3:0] data_cnt;
  int         errors = 0, checks = 0;
  logic [7:0] mq[$];
  logic       movf = 0, mudf = 0;

  i2c_txff dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .empty(empty), .level(level), .i_txff_rd(i_txff_rd), .data_in(data_in),
    .data_cnt(data_cnt), .ovf(ovf), .udf(udf), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n = mq.size();
    chk({tag, ":level"}, 32'(level), 32'(n));
    chk({tag, ":empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ":full"}, 32'(full), 32'(n == 16));
    chk({tag, ":data_cnt"}, 32'(data_cnt), 32'(n > 15 ? 15 : n));
    chk({tag, ":ovf"}, 32'(ovf), 32'(movf));
    chk({tag, ":udf"}, 32'(udf), 32'(mudf));
    chk({tag, ":data_in"}, 32'(data_in), 32'(n == 0 ? 8'h00 : mq[0]));
  endtask

  // one cycle: drive inputs, score the pop, update model, clock, check outputs
  task automatic step(input string tag, input logic wr, input logic [7:0] d,
                      input logic rd, input logic clr);
    logic       p, q;
    logic [7:0] exp;
    wr_en = wr; wr_data = d; i_txff_rd = rd; clr_err = clr;
    p = rd && mq.size() > 0;
    q = wr && (mq.size() < 16 || p);
    if (rd && mq.size() == 0) mudf = 1;
    else if (clr) mudf = 0;
    if (wr && !q) movf = 1;
    else if (clr) movf = 0;
    if (p) begin
      exp = mq.pop_front();
      chk({tag, ":pop"}, 32'(data_in), 32'(exp));
    end
    if (q) mq.push_back(d);
    @(posedge clk); #1;
    wr_en = 0; i_txff_rd = 0; clr_err = 0;
    check_all(tag);
  endtask

  initial begin
    // reset with random inputs toggling
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'($urandom); i_txff_rd = 1'($urandom); clr_err = 1'($urandom);
      wr_data = 8'($urandom);
      @(posedge clk); #1;
    end
    wr_en = 0; i_txff_rd = 0; clr_err = 0;
    check_all("reset");
    rst = 1;
    step("release", 0, 8'h00, 0, 0);
    // FWFT ordering
    step("push_a1", 1, 8'hA1, 0, 0);
    step("push_b2", 1, 8'hB2, 0, 0);
    step("push_c3", 1, 8'hC3, 0, 0);
    for (int i = 0; i < 3; i++) step("pop_abc", 0, 8'h00, 1, 0);
    // fill and wrap
    for (int i = 0; i < 16; i++) step("fill", 1, 8'(i), 0, 0);
    for (int i = 0; i < 4; i++) step("pop4", 0, 8'h00, 1, 0);
    for (int i = 0; i < 4; i++) step("refill", 1, 8'(16 + i), 0, 0);
    for (int i = 0; i < 16; i++) step("drain", 0, 8'h00, 1, 0);
    // full corner
    for (int i = 0; i < 16; i++) step("fill2", 1, 8'(8'h20 + i), 0, 0);
    step("full_push", 1, 8'hEE, 0, 0);
    step("full_both", 1, 8'h55, 1, 0);
    for (int i = 0; i < 16; i++) step("drain2", 0, 8'h00, 1, 0);
    // empty corner
    step("empty_pop", 0, 8'h00, 1, 0);
    step("empty_both", 1, 8'h77, 1, 0);
    // flag clear, then set-wins against clear
    step("clr", 0, 8'h00, 0, 1);
    for (int i = 0; i < 15; i++) step("fill3", 1, 8'(8'h40 + i), 0, 0);
    step("ovf_clr", 1, 8'h99, 0, 1);
    for (int i = 0; i < 11; i++) step("to5", 0, 8'h00, 1, 0);
    // asynchronous reset away from any clock edge
    #2 rst = 0;
    #1;
    mq.delete(); movf = 0; mudf = 0;
    check_all("async_rst");
    wr_en = 1; wr_data = 8'h3C; i_txff_rd = 1;
    @(posedge clk); #1;
    wr_en = 0; i_txff_rd = 0;
    check_all("in_rst");
    rst = 1;
    step("post_rst", 1, 8'h3C, 0, 0);
    step("post_pop", 0, 8'h00, 1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/i2c_txff.md
Name: i2c_txff

Overview:
- Transmit byte FIFO sitting directly upstream of the I2C master.
- Host logic pushes payload bytes; the master pops them with its single-cycle i_txff_rd strobe.
- Head byte is presented first-word-fall-through on data_in.
- Saturated occupancy is exported as the master's 4-bit data_cnt, with full/empty and sticky overflow/underflow status for the host.

Parameters:
- DW, 8, data byte width (must match the master's data_in).
- DEPTH, 16, number of entries; power of two, minimum 2.
- AW, 4, pointer width, equal to log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- wr_en  input  1  host push request.
- wr_data  input  DW  byte to push.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- level  output  AW+1  current occupancy, 0..DEPTH.
- i_txff_rd  input  1  pop strobe from master, one pop per asserted cycle.
- data_in  output  DW  head-of-FIFO byte to master.
- data_cnt  output  4  occupancy saturated at 15, to master.
- ovf  output  1  sticky: a push was dropped because FIFO was full.
- udf  output  1  sticky: a pop arrived while FIFO was empty.
- clr_err  input  1  clears ovf/udf.

Behaviour:
- Reset (rst=0, asynchronous assert, synchronous release):
  - wr_ptr=0, rd_ptr=0, level=0.
  - empty=1, full=0, data_cnt=0, ovf=0, udf=0, data_in=0.
  - Memory contents are not reset.
- Storage: DEPTH x DW register array.
  - wr_ptr and rd_ptr are AW bits wide and wrap from DEPTH-1 to 0 by natural overflow.
  - level is held in a separate AW+1-bit counter.
- Push accepted when wr_en=1 and (full=0, or a pop is accepted in the same cycle):
  - mem[wr_ptr] <= wr_data.
  - wr_ptr increments.
- Pop accepted when i_txff_rd=1 and empty=0:
  - rd_ptr increments.
- Level update: +1 on push-only, -1 on pop-only, unchanged on push+pop or neither.
- Flag and count derivation:
  - full = (level==DEPTH); empty = (level==0). Both are registered, updated with level.
  - data_cnt = (level>15) ? 15 : level[3:0]. Registered, same cycle as level.
- data_in:
  - Equals mem[rd_ptr] when empty=0; forced to 0 when empty=1.
  - Combinational from registered state; no cycle-level glitch requirement beyond that.
- Latency:
  - A byte pushed into an empty FIFO at edge N appears on data_in, with empty=0, after edge N.
  - After a pop at edge N, the next byte is on data_in after edge N.
- Boundary: full with wr_en and i_txff_rd together:
  - Both accepted; the new byte is written to the freed slot.
  - level stays DEPTH; ovf is not set.
- Boundary: full with wr_en only:
  - Push dropped; memory and pointers unchanged.
  - ovf <= 1.
- Boundary: empty with i_txff_rd and wr_en together:
  - Pop ignored; udf <= 1.
  - Push accepted; level becomes 1.
- Boundary: empty with i_txff_rd only:
  - udf <= 1; pointers unchanged.
- Error flags:
  - clr_err=1 clears ovf and udf on the next edge.
  - If a new overflow/underflow occurs in the same cycle as clr_err, the set wins.
- Reset mid-operation:
  - Immediately returns all outputs to their reset values.
  - Previously stored bytes are lost (level=0); no pop or push is honoured while rst=0.
- No combinational path from wr_en to any output; i_txff_rd affects outputs only after a clock edge.

Test Plan:
1. Reset check: rst=0 with random inputs → empty=1, full=0, level=0, data_cnt=0, data_in=8'h00, ovf=udf=0. Release rst → values hold until a push.
2. FWFT ordering: push 8'hA1, 8'hB2, 8'hC3 → data_in=8'hA1 one cycle after the first push, level=3, data_cnt=3. Pop three times → data_in sequence A1, B2, C3, then 0 with empty=1.
3. Fill/wrap: push 16 bytes 8'h00..8'h0F → full=1, level=16, data_cnt=15. Pop 4, push 8'h10..8'h13, pop all 16 → output sequence 04..13 in order, verifying pointer wrap.
4. Full corner: at full, wr_en=1 alone with 8'hEE → ovf=1, level=16, 8'hEE never appears. Then wr_en and i_txff_rd together with 8'h55 → level=16, ovf unchanged, 8'h55 appears last.
5. Empty corner: at empty, i_txff_rd=1 alone → udf=1, level=0. Then i_txff_rd and wr_en=8'h77 together → level=1, data_in=8'h77.
6. Flag clear and async reset: clr_err=1 → ovf=udf=0 next cycle; clr_err together with an overflowing push → ovf stays 1. With 5 bytes stored, assert rst mid-cycle → level=0 and empty=1 without waiting for a clock edge.
